// File: rtl/req_priority_arbiter_if.sv
// Request/grant bundle between the requesting agents and req_priority_arbiter.
// Handshake: req[i] is a level request; a registered one-hot grant answers it and is held while req[i] stays high.
interface req_priority_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;
  logic       state_dbg;

  modport master (
    output req,
    input  grant, grant_id, grant_valid, timeout, state_dbg
  );

  modport slave (
    input  req,
    output grant, grant_id, grant_valid, timeout, state_dbg
  );
endinterface

// File: rtl/req_priority_arbiter.sv
// 8-way hold-until-release arbiter with a hold timeout and a mandatory idle bubble.
// Optional macro ARB_ROUND_ROBIN_EN switches fixed priority (bit 7 highest) to rotating priority.
module req_priority_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  req_priority_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] req_s;
  logic [2:0]       win_id;

  assign req_s         = bus.req;
  assign bus.state_dbg = (state == GRANT);

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
  logic       rr_primed;
  logic [2:0] start;
  logic [2:0] idx;
  logic       found;

  // Before the first grant the search starts at 7, so the sequence opens 7,6,5,...
  always_comb begin
    start  = rr_primed ? rr_ptr - 3'd1 : 3'd7;
    win_id = 3'd0;
    idx    = 3'd0;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start - 3'(k);
      if (!found && req_s[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 3'd7;
      rr_primed <= 1'b0;
    end else if (state == IDLE && |req_s) begin
      rr_ptr    <= win_id;
      rr_primed <= 1'b1;
    end
  end
`else
  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req_s[i]) win_id = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.grant       <= 8'h00;
      bus.grant_id    <= 3'd0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|req_s) begin
            state           <= GRANT;
            bus.grant_id    <= win_id;
            bus.grant       <= 8'b1 << win_id;
            bus.grant_valid <= 1'b1;
            cnt             <= CNT_W'(1);
          end
        end
        GRANT: begin
          // Every release lands in IDLE, which provides the one-cycle bubble.
          if (!req_s[bus.grant_id] || cnt >= CNT_W'(MAX_HOLD)) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.grant       <= 8'h00;
            bus.grant_id    <= 3'd0;
            bus.grant_valid <= 1'b0;
            bus.timeout     <= req_s[bus.grant_id];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/req_priority_arbiter.md
Name: req_priority_arbiter

Overview:
- Sequential arbiter that shares one downstream resource among 8 requesters.
- Priority is resolved with the same 8:3 encoding as the team's priority encoder: bit 7 is highest, bit 0 is lowest, and the 3-bit index is the encoded value.
- The winner's grant is held for as long as its request stays high, bounded by a hold-timeout counter.
- Sits between requesting agents and a single shared datapath port.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 so the grant index stays 3 bits.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants the resource.
- grant  output  8  one-hot grant, registered; all zeros when idle.
- grant_id  output  3  encoded index of the granted requester; 0 when idle.
- grant_valid  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, active-high): grant=0, grant_id=0, grant_valid=0, timeout=0, hold counter=0, state=IDLE, RR pointer=7.
- All outputs are registered. There are no combinational paths from req to any output.
- Reset asserted mid-grant clears everything immediately. The first grant after reset deassertion comes no earlier than 1 clock after the first sampled req.
- State machine: IDLE, GRANT.
  - IDLE, req==0: stay in IDLE; outputs stay 0.
  - IDLE, req!=0: go to GRANT; register the winner's index into grant_id, set grant=1<<index and grant_valid=1, clear the counter to 1. Latency from req sampled high to grant visible is 1 cycle.
  - GRANT, req[grant_id]==1 and counter<MAX_HOLD: stay in GRANT; counter increments.
  - GRANT, req[grant_id]==0: go to IDLE; grant, grant_valid and grant_id go to 0 on that edge.
  - GRANT, req[grant_id]==1 and counter==MAX_HOLD: go to IDLE; clear grant; pulse timeout=1 for exactly one cycle.
- After every release there is exactly one idle cycle (grant_valid=0) before the next grant. This bubble is mandatory even if other requests are pending.
- Requests arriving or changing on non-granted bits during GRANT are ignored. There is no preemption: a higher-priority request never revokes a current grant.
- Simultaneous requests: resolved per the priority rule in a single cycle. The grant is always one-hot or zero; never multi-hot.
- Timed-out requester: holds no special penalty in fixed mode. If it still requests, it competes normally after the bubble.
- Counter saturates and does not wrap. It is reset to 0 in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - The RR pointer records the last granted index and updates on each grant.
  - Search order starts at pointer-1 and descends, wrapping 0 to 7 (mod 8).
  - With all 8 requests held high continuously, grants cycle 7,6,5,...,0,7 across successive grants.
- Undefined: fixed priority, bit 7 highest. The RR pointer logic is not compiled.

Test Plan:
- Reset: assert rst mid-grant (grant=8'h80) → all outputs 0 asynchronously, before the next clk edge.
- Fixed priority: req=8'b0010_0110 → 1 cycle later grant=8'b0010_0000, grant_id=5, grant_valid=1. Drop req[5] → next edge grant=0, one bubble cycle, then grant_id=2.
- No preemption: grant_id=1 held; raise req[7] → grant stays 8'h02 until req[1] drops, then bubble, then grant=8'h80.
- Timeout (MAX_HOLD=4): req=8'h01 held high → grant_valid high for exactly 4 cycles, timeout pulses for 1 cycle, 1 idle cycle, then re-grant of 8'h01.
- Round-robin (ARB_ROUND_ROBIN_EN): req=8'hFF held, each requester released after 1 grant cycle → grant_id sequence 7,6,5,4,3,2,1,0,7. With the macro undefined, the same stimulus gives 7,7,7,...
- Idle: req=0 for 20 cycles → grant=0, grant_valid=0, timeout=0 throughout.
